// File: rtl/cam_pkg.sv
// ============================================================================
// Module   : cam_pkg
// Purpose  : Shared opcode and FSM state types for the CAM register file.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package cam_pkg;

  typedef enum logic [1:0] {
    CAM_LOOKUP      = 2'd0,
    CAM_REPLACE_ALL = 2'd1,
    CAM_WRITE_ADDR  = 2'd2,
    CAM_ENUM        = 2'd3
  } cam_op_t;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_ENUM = 1'b1
  } cam_state_t;

endpackage

`default_nettype wire

// File: rtl/cam_prio_enc.sv
// ============================================================================
// Module   : cam_prio_enc
// Purpose  : Reduces a match vector to any-hit, lowest/highest index, popcount.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module cam_prio_enc #(
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic [DEPTH-1:0] match,
  output logic             any,
  output logic [AW-1:0]    lowest,
  output logic [AW-1:0]    highest,
  output logic [CW-1:0]    count
);

  // Scan directions are opposite so the last assignment wins as the extreme index.
  always_comb begin
    lowest  = '0;
    highest = '0;
    count   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (match[i]) lowest = AW'(i);
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (match[i]) highest = AW'(i);
      count = count + CW'(match[i]);
    end
  end

  assign any = |match;

endmodule

`default_nettype wire

// File: rtl/cam_regfile_ctrl.sv
// ============================================================================
// Module   : cam_regfile_ctrl
// Purpose  : Parametrised content-addressable register file with lookup,
//            replace-all, direct write and multi-beat match enumeration.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module cam_regfile_ctrl
  import cam_pkg::*;
#(
  parameter  int DATA_W    = 4,
  parameter  int DEPTH     = 8,
  parameter  int INIT_BASE = 8,
  localparam int AW        = $clog2(DEPTH),
  localparam int CW        = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              init,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [DATA_W-1:0] req_key,
  input  logic [DATA_W-1:0] req_data,
  input  logic [AW-1:0]     req_addr,
  output logic              rsp_valid,
  output logic              rsp_hit,
  output logic [AW-1:0]     rsp_min,
  output logic [AW-1:0]     rsp_max,
  output logic [CW-1:0]     rsp_count,
  output logic [AW-1:0]     rsp_addr,
  output logic              rsp_last
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  cam_state_t        r_state;
  cam_state_t        w_state_nxt;
  logic [DEPTH-1:0]  r_snap;
  logic [DEPTH-1:0]  w_snap_nxt;

  logic [DEPTH-1:0]  w_match;
  logic [DEPTH-1:0]  w_wr_en;
  logic              w_accept;
  logic              w_addr_ok;
  cam_op_t           w_op;

  logic              w_live_any;
  logic [AW-1:0]     w_live_min;
  logic [AW-1:0]     w_live_max;
  logic [CW-1:0]     w_live_count;

  logic              w_snap_any;
  logic [AW-1:0]     w_snap_min;
  logic [AW-1:0]     w_snap_max;
  logic [CW-1:0]     w_snap_count;
  logic              w_unused_snap;

  logic              w_valid_nxt;
  logic              w_hit_nxt;
  logic [AW-1:0]     w_min_nxt;
  logic [AW-1:0]     w_max_nxt;
  logic [CW-1:0]     w_count_nxt;
  logic [AW-1:0]     w_addr_nxt;
  logic              w_last_nxt;

  assign w_op      = cam_op_t'(req_op);
  assign req_ready = ~init & (r_state == S_IDLE);
  assign w_accept  = req_valid & req_ready;

  // Only a non-power-of-two depth leaves address codes without a backing entry.
  if (DEPTH == (1 << AW)) begin : g_addr_full
    assign w_addr_ok = 1'b1;
  end else begin : g_addr_partial
    localparam logic [AW:0] c_depth = (AW + 1)'(DEPTH);
    assign w_addr_ok = ({1'b0, req_addr} < c_depth);
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_match[i] = (r_mem[i] == req_key);
    end
  end

  cam_prio_enc #(.DEPTH(DEPTH)) u_enc_live (
    .match   (w_match),
    .any     (w_live_any),
    .lowest  (w_live_min),
    .highest (w_live_max),
    .count   (w_live_count)
  );

  cam_prio_enc #(.DEPTH(DEPTH)) u_enc_snap (
    .match   (r_snap),
    .any     (w_snap_any),
    .lowest  (w_snap_min),
    .highest (w_snap_max),
    .count   (w_snap_count)
  );

  assign w_unused_snap = ^{w_snap_any, w_snap_max};

  always_comb begin
    w_wr_en = '0;
    if (w_accept) begin
      for (int i = 0; i < DEPTH; i++) begin
        if ((w_op == CAM_REPLACE_ALL && w_match[i]) ||
            (w_op == CAM_WRITE_ADDR && req_addr == AW'(i))) begin
          w_wr_en[i] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge init) begin
    if (init) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= DATA_W'(INIT_BASE + i);
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_wr_en[i]) r_mem[i] <= req_data;
      end
    end
  end

  always_ff @(posedge clk or posedge init) begin
    if (init) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // The first ENUM beat is taken straight from the live vector; the snapshot
  // holds only the indices still to be emitted.
  always_comb begin
    w_state_nxt = r_state;
    w_snap_nxt  = r_snap;
    w_valid_nxt = 1'b0;
    w_hit_nxt   = rsp_hit;
    w_min_nxt   = rsp_min;
    w_max_nxt   = rsp_max;
    w_count_nxt = rsp_count;
    w_addr_nxt  = rsp_addr;
    w_last_nxt  = rsp_last;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_valid_nxt = 1'b1;
          w_hit_nxt   = w_live_any;
          w_min_nxt   = w_live_min;
          w_max_nxt   = w_live_max;
          w_count_nxt = w_live_count;
          w_addr_nxt  = w_live_min;
          w_last_nxt  = 1'b1;
          if (w_op == CAM_WRITE_ADDR) begin
            w_hit_nxt   = w_addr_ok;
            w_min_nxt   = w_addr_ok ? req_addr : '0;
            w_max_nxt   = w_addr_ok ? req_addr : '0;
            w_addr_nxt  = w_addr_ok ? req_addr : '0;
            w_count_nxt = w_addr_ok ? CW'(1) : '0;
          end else if (w_op == CAM_ENUM) begin
            w_snap_nxt = w_match & (w_match - DEPTH'(1));
            w_last_nxt = (w_live_count <= CW'(1));
            if (w_live_count > CW'(1)) w_state_nxt = S_ENUM;
          end
        end
      end
      S_ENUM: begin
        w_valid_nxt = 1'b1;
        w_addr_nxt  = w_snap_min;
        w_snap_nxt  = r_snap & (r_snap - DEPTH'(1));
        w_last_nxt  = (w_snap_count == CW'(1));
        if (w_snap_count == CW'(1)) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge init) begin
    if (init) begin
      r_snap    <= '0;
      rsp_valid <= 1'b0;
      rsp_hit   <= 1'b0;
      rsp_min   <= '0;
      rsp_max   <= '0;
      rsp_count <= '0;
      rsp_addr  <= '0;
      rsp_last  <= 1'b0;
    end else begin
      r_snap    <= w_snap_nxt;
      rsp_valid <= w_valid_nxt;
      rsp_hit   <= w_hit_nxt;
      rsp_min   <= w_min_nxt;
      rsp_max   <= w_max_nxt;
      rsp_count <= w_count_nxt;
      rsp_addr  <= w_addr_nxt;
      rsp_last  <= w_last_nxt;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cam_regfile_ctrl.sv
// ============================================================================
// Module   : tb_cam_regfile_ctrl
// Purpose  : Directed self-checking bench for cam_regfile_ctrl (two configs).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_cam_regfile_ctrl;
  import cam_pkg::*;

  logic       clk = 1'b0;
  logic       init;
  int         n_tests = 0;
  int         n_fail  = 0;

  // Default configuration: DATA_W=4, DEPTH=8, INIT_BASE=8
  logic       req_valid, req_ready, rsp_valid, rsp_hit, rsp_last;
  logic [1:0] req_op;
  logic [3:0] req_key, req_data;
  logic [2:0] req_addr, rsp_min, rsp_max, rsp_addr;
  logic [3:0] rsp_count;

  // Alternate configuration: DATA_W=6, DEPTH=12, INIT_BASE=60
  logic       req6_valid, req6_ready, rsp6_valid, rsp6_hit, rsp6_last;
  logic [1:0] req6_op;
  logic [5:0] req6_key, req6_data;
  logic [3:0] req6_addr, rsp6_min, rsp6_max, rsp6_addr, rsp6_count;

  int         exp_addr [3];

  always #5 clk = ~clk;

  cam_regfile_ctrl u_dut (
    .clk       (clk),
    .init      (init),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_key   (req_key),
    .req_data  (req_data),
    .req_addr  (req_addr),
    .rsp_valid (rsp_valid),
    .rsp_hit   (rsp_hit),
    .rsp_min   (rsp_min),
    .rsp_max   (rsp_max),
    .rsp_count (rsp_count),
    .rsp_addr  (rsp_addr),
    .rsp_last  (rsp_last)
  );

  cam_regfile_ctrl #(.DATA_W(6), .DEPTH(12), .INIT_BASE(60)) u_dut6 (
    .clk       (clk),
    .init      (init),
    .req_valid (req6_valid),
    .req_ready (req6_ready),
    .req_op    (req6_op),
    .req_key   (req6_key),
    .req_data  (req6_data),
    .req_addr  (req6_addr),
    .rsp_valid (rsp6_valid),
    .rsp_hit   (rsp6_hit),
    .rsp_min   (rsp6_min),
    .rsp_max   (rsp6_max),
    .rsp_count (rsp6_count),
    .rsp_addr  (rsp6_addr),
    .rsp_last  (rsp6_last)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [3:0] key,
                       input logic [3:0] data, input logic [2:0] addr);
    req_valid = 1'b1;
    req_op    = op;
    req_key   = key;
    req_data  = data;
    req_addr  = addr;
    tick();
  endtask

  task automatic issue6(input logic [1:0] op, input logic [5:0] key,
                        input logic [5:0] data, input logic [3:0] addr);
    req6_valid = 1'b1;
    req6_op    = op;
    req6_key   = key;
    req6_data  = data;
    req6_addr  = addr;
    tick();
    req6_valid = 1'b0;
  endtask

  task automatic idle();
    req_valid = 1'b0;
    tick();
  endtask

  task automatic do_init();
    req_valid = 1'b0;
    init      = 1'b1;
    tick();
    init      = 1'b0;
    #1;
  endtask

  task automatic check_rsp(input string tag, input logic hit, input int mn, input int mx,
                           input int cnt, input int addr, input logic last);
    check({tag, ".valid"}, rsp_valid, 1);
    check({tag, ".hit"},   rsp_hit,   hit);
    check({tag, ".min"},   rsp_min,   mn);
    check({tag, ".max"},   rsp_max,   mx);
    check({tag, ".count"}, rsp_count, cnt);
    check({tag, ".addr"},  rsp_addr,  addr);
    check({tag, ".last"},  rsp_last,  last);
  endtask

  initial begin
    init = 1'b1; req_valid = 1'b0; req_op = '0; req_key = '0; req_data = '0; req_addr = '0;
    req6_valid = 1'b0; req6_op = '0; req6_key = '0; req6_data = '0; req6_addr = '0;
    tick();
    check("rst.ready_in_init", req_ready, 0);
    check("rst.valid", rsp_valid, 0);
    check("rst.outs", {rsp_hit, rsp_min, rsp_max, rsp_count, rsp_addr, rsp_last}, 0);
    init = 1'b0;
    #1;
    check("rst.ready_after", req_ready, 1);

    // Lookups against reset contents 8..F
    issue(CAM_LOOKUP, 4'hA, 4'h0, 3'd0);
    check_rsp("lk_A", 1, 2, 2, 1, 2, 1);
    issue(CAM_LOOKUP, 4'h3, 4'h0, 3'd0);
    check_rsp("lk_3", 0, 0, 0, 0, 0, 1);
    idle();
    check("pulse.valid", rsp_valid, 0);

    // Replace-all reports pre-write matches; follow-up lookup sees new contents
    issue(CAM_REPLACE_ALL, 4'h8, 4'hC, 3'd0);
    check_rsp("rep_8C", 1, 0, 0, 1, 0, 1);
    issue(CAM_LOOKUP, 4'hC, 4'h0, 3'd0);
    check_rsp("lk_C", 1, 0, 4, 2, 0, 1);
    idle();

    // Back-to-back writes then a three-beat enumeration (matches 4, 6, 7)
    do_init();
    issue(CAM_WRITE_ADDR, 4'h0, 4'hC, 3'd6);
    check_rsp("wr6", 1, 6, 6, 1, 6, 1);
    issue(CAM_WRITE_ADDR, 4'h0, 4'hC, 3'd7);
    check_rsp("wr7", 1, 7, 7, 1, 7, 1);
    issue(CAM_ENUM, 4'hC, 4'h0, 3'd0);
    req_valid = 1'b0;
    exp_addr = '{4, 6, 7};
    for (int b = 0; b < 3; b++) begin
      check_rsp($sformatf("enum_b%0d", b), 1, 4, 7, 3, exp_addr[b], (b == 2));
      check($sformatf("enum_b%0d.ready", b), req_ready, (b == 2));
      if (b < 2) tick();
    end
    tick();
    check("enum_end.valid", rsp_valid, 0);

    // Enumeration with no matches is a single terminal beat
    do_init();
    issue(CAM_ENUM, 4'h0, 4'h0, 3'd0);
    check_rsp("enum0", 0, 0, 0, 0, 0, 1);
    check("enum0.ready", req_ready, 1);
    idle();
    check("enum0_after.valid", rsp_valid, 0);
    check("enum0_after.ready", req_ready, 1);

    // Reset asserted during beat 2 of a three-match enumeration (1, 2, 4)
    do_init();
    issue(CAM_WRITE_ADDR, 4'h0, 4'hC, 3'd1);
    issue(CAM_WRITE_ADDR, 4'h0, 4'hC, 3'd2);
    issue(CAM_ENUM, 4'hC, 4'h0, 3'd0);
    req_valid = 1'b0;
    check_rsp("abort_b0", 1, 1, 4, 3, 1, 0);
    tick();
    check_rsp("abort_b1", 1, 1, 4, 3, 2, 0);
    #1 init = 1'b1;
    #1;
    check("abort.valid_async", rsp_valid, 0);
    check("abort.ready", req_ready, 0);
    tick();
    init = 1'b0;
    #1;
    check("abort.valid_after", rsp_valid, 0);
    check("abort.ready_after", req_ready, 1);
    issue(CAM_LOOKUP, 4'hF, 4'h0, 3'd0);
    check_rsp("abort_lkF", 1, 7, 7, 1, 7, 1);
    issue(CAM_LOOKUP, 4'hC, 4'h0, 3'd0);
    check_rsp("abort_lkC", 1, 4, 4, 1, 4, 1);
    idle();

    // Alternate configuration: wrap-around init and out-of-range write
    issue6(CAM_LOOKUP, 6'd0, 6'd0, 4'd0);
    check("w6_lk0.valid", rsp6_valid, 1);
    check("w6_lk0.hit", rsp6_hit, 1);
    check("w6_lk0.min", rsp6_min, 4);
    check("w6_lk0.max", rsp6_max, 4);
    check("w6_lk0.count", rsp6_count, 1);
    issue6(CAM_WRITE_ADDR, 6'd0, 6'd20, 4'd13);
    check("w6_wr13.hit", rsp6_hit, 0);
    check("w6_wr13.count", rsp6_count, 0);
    check("w6_wr13.last", rsp6_last, 1);
    issue6(CAM_LOOKUP, 6'd20, 6'd0, 4'd0);
    check("w6_lk20.hit", rsp6_hit, 0);
    check("w6_lk20.count", rsp6_count, 0);
    issue6(CAM_WRITE_ADDR, 6'd0, 6'd20, 4'd11);
    check("w6_wr11.hit", rsp6_hit, 1);
    check("w6_wr11.addr", rsp6_addr, 11);
    issue6(CAM_LOOKUP, 6'd20, 6'd0, 4'd0);
    check("w6_lk20b.hit", rsp6_hit, 1);
    check("w6_lk20b.min", rsp6_min, 11);
    check("w6_lk20b.max", rsp6_max, 11);
    check("w6_lk20b.count", rsp6_count, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
